// File: rtl/mac_pkg.sv
// Package: mac_pkg
// Opcode encodings and decode helpers for the multiply/multiply-accumulate
// unit. The control_unit decoder uses the same definitions.
package mac_pkg;

  localparam int MAC_OPC_W = 4;
  localparam int MAC_TAG_W = 4;

  localparam logic [MAC_OPC_W-1:0] MAC_OP_MUL   = 4'b0000;
  localparam logic [MAC_OPC_W-1:0] MAC_OP_MLA   = 4'b0001;
  localparam logic [MAC_OPC_W-1:0] MAC_OP_UMULL = 4'b0100;
  localparam logic [MAC_OPC_W-1:0] MAC_OP_UMLAL = 4'b0101;
  localparam logic [MAC_OPC_W-1:0] MAC_OP_SMULL = 4'b0110;
  localparam logic [MAC_OPC_W-1:0] MAC_OP_SMLAL = 4'b0111;

  // Ops that produce and write a 2*WIDTH result.
  function automatic logic is_long_op(input logic [MAC_OPC_W-1:0] opcode);
    case (opcode)
      MAC_OP_UMULL, MAC_OP_UMLAL, MAC_OP_SMULL, MAC_OP_SMLAL: is_long_op = 1'b1;
      default:                                                is_long_op = 1'b0;
    endcase
  endfunction

  // Ops that sign-extend their multiplicands.
  function automatic logic is_signed_op(input logic [MAC_OPC_W-1:0] opcode);
    case (opcode)
      MAC_OP_SMULL, MAC_OP_SMLAL: is_signed_op = 1'b1;
      default:                    is_signed_op = 1'b0;
    endcase
  endfunction

  // Ops that add an accumulator to the product.
  function automatic logic is_acc_op(input logic [MAC_OPC_W-1:0] opcode);
    case (opcode)
      MAC_OP_MLA, MAC_OP_UMLAL, MAC_OP_SMLAL: is_acc_op = 1'b1;
      default:                                is_acc_op = 1'b0;
    endcase
  endfunction

  // One of the six defined mul-class encodings.
  function automatic logic is_legal_op(input logic [MAC_OPC_W-1:0] opcode);
    case (opcode)
      MAC_OP_MUL, MAC_OP_MLA, MAC_OP_UMULL,
      MAC_OP_UMLAL, MAC_OP_SMULL, MAC_OP_SMLAL: is_legal_op = 1'b1;
      default:                                  is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multiply_accumulate_unit_if.sv
// Interface: mac_if
// Request and result handshakes of the multiply/multiply-accumulate unit.
// slave = the unit, master = the issuing side.
interface mac_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_opcode;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [WIDTH-1:0]     in_c;
  logic [WIDTH-1:0]     in_d;
  logic [3:0]           in_dest_lo;
  logic [3:0]           in_dest_hi;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_result;
  logic                 out_long;
  logic [3:0]           out_dest_lo;
  logic [3:0]           out_dest_hi;
  logic                 out_illegal;
  logic [1:0]           out_flags;

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, in_c, in_d, in_dest_lo, in_dest_hi, out_ready,
    output in_ready, out_valid, out_result, out_long, out_dest_lo, out_dest_hi,
           out_illegal, out_flags
  );

  modport master (
    output in_valid, in_opcode, in_a, in_b, in_c, in_d, in_dest_lo, in_dest_hi, out_ready,
    input  in_ready, out_valid, out_result, out_long, out_dest_lo, out_dest_hi,
           out_illegal, out_flags
  );
endinterface

// File: rtl/mac_pipe_stage.sv
// Module: mac_pipe_stage
// One pipeline register slice: a valid bit plus a flat payload. Moves only
// when en is high; payload is captured only for valid entries.
module mac_pipe_stage #(
  parameter int PW = 76
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          in_valid,
  input  logic [PW-1:0] in_payload,
  output logic          out_valid,
  output logic [PW-1:0] out_payload
);

  logic          valid_r;
  logic [PW-1:0] payload_r;

  // Slice register: cleared by reset, advanced by the global enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r   <= 1'b0;
      payload_r <= {PW{1'b0}};
    end else if (en) begin
      valid_r <= in_valid;
      if (in_valid) begin
        payload_r <= in_payload;
      end
    end
  end

  assign out_valid   = valid_r;
  assign out_payload = payload_r;

endmodule

// File: rtl/multiply_accumulate_unit.sv
// Module: multiply_accumulate_unit
// Pipelined MUL/MLA/UMULL/UMLAL/SMULL/SMLAL unit with valid/ready on both
// sides and writeback tags carried alongside the result. The arithmetic is
// resolved ahead of the first register; the remaining STAGES-1 slices only
// delay it, so latency is exactly STAGES cycles. All stages stall together.
// Optional feature: define MAC_FLAGS_EN to build the {N,Z} result flags.
module multiply_accumulate_unit
  import mac_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  mac_if.slave bus
);

  // Payload layout: {illegal, long, flags[1:0], dest_hi, dest_lo, result}
  localparam int RW = 2 * WIDTH;
  localparam int PW = RW + 2 + 2 + 2 * MAC_TAG_W;

  logic          adv_s;
  logic          legal_s;
  logic          long_s;
  logic          signed_s;
  logic          acc_s;
  logic [RW-1:0] a_ext_s;
  logic [RW-1:0] b_ext_s;
  logic [RW-1:0] acc_val_s;
  logic [RW-1:0] prod_s;
  logic [RW-1:0] sum_s;
  logic [RW-1:0] res_s;
  logic [1:0]    flags_s;
  logic [PW-1:0] stage_in_s;

  logic          valid_s   [STAGES];
  logic [PW-1:0] payload_s [STAGES];

  // Global advance: everything moves unless a result is held at the output.
  assign adv_s       = !valid_s[STAGES-1] || bus.out_ready;
  assign bus.in_ready = adv_s;

  // Decode, operand extension, multiply and accumulate.
  always_comb begin
    legal_s   = is_legal_op(bus.in_opcode);
    long_s    = is_long_op(bus.in_opcode);
    signed_s  = is_signed_op(bus.in_opcode);
    acc_s     = is_acc_op(bus.in_opcode);
    a_ext_s   = {{WIDTH{1'b0}}, bus.in_a};
    b_ext_s   = {{WIDTH{1'b0}}, bus.in_b};
    acc_val_s = {RW{1'b0}};
    res_s     = {RW{1'b0}};
    if (signed_s) begin
      a_ext_s = {{WIDTH{bus.in_a[WIDTH-1]}}, bus.in_a};
      b_ext_s = {{WIDTH{bus.in_b[WIDTH-1]}}, bus.in_b};
    end else begin
      a_ext_s = {{WIDTH{1'b0}}, bus.in_a};
      b_ext_s = {{WIDTH{1'b0}}, bus.in_b};
    end
    if (!acc_s) begin
      acc_val_s = {RW{1'b0}};
    end else if (long_s) begin
      acc_val_s = {bus.in_d, bus.in_c};
    end else begin
      acc_val_s = {{WIDTH{1'b0}}, bus.in_c};
    end
    prod_s = a_ext_s * b_ext_s;
    sum_s  = prod_s + acc_val_s;
    if (!legal_s) begin
      res_s = {RW{1'b0}};
    end else if (long_s) begin
      res_s = sum_s;
    end else begin
      res_s = {{WIDTH{1'b0}}, sum_s[WIDTH-1:0]};
    end
  end

`ifdef MAC_FLAGS_EN
  // N is the MSB of the written portion, Z flags an all-zero written portion.
  always_comb begin
    flags_s = 2'b00;
    if (!legal_s) begin
      flags_s = 2'b00;
    end else if (long_s) begin
      flags_s = {res_s[RW-1], (res_s == {RW{1'b0}})};
    end else begin
      flags_s = {res_s[WIDTH-1], (res_s[WIDTH-1:0] == {WIDTH{1'b0}})};
    end
  end
`else
  assign flags_s = 2'b00;
`endif

  assign stage_in_s = {!legal_s, long_s && legal_s, flags_s,
                       bus.in_dest_hi, bus.in_dest_lo, res_s};

  mac_pipe_stage #(.PW(PW)) u_stage0 (
    .clk         (clk),
    .rst         (rst),
    .en          (adv_s),
    .in_valid    (bus.in_valid),
    .in_payload  (stage_in_s),
    .out_valid   (valid_s[0]),
    .out_payload (payload_s[0])
  );

  for (genvar g = 1; g < STAGES; g++) begin : g_stage
    mac_pipe_stage #(.PW(PW)) u_stage (
      .clk         (clk),
      .rst         (rst),
      .en          (adv_s),
      .in_valid    (valid_s[g-1]),
      .in_payload  (payload_s[g-1]),
      .out_valid   (valid_s[g]),
      .out_payload (payload_s[g])
    );
  end

  assign bus.out_valid   = valid_s[STAGES-1];
  assign bus.out_result  = payload_s[STAGES-1][RW-1:0];
  assign bus.out_dest_lo = payload_s[STAGES-1][RW+3:RW];
  assign bus.out_dest_hi = payload_s[STAGES-1][RW+7:RW+4];
  assign bus.out_flags   = payload_s[STAGES-1][RW+9:RW+8];
  assign bus.out_long    = payload_s[STAGES-1][RW+10];
  assign bus.out_illegal = payload_s[STAGES-1][RW+11];

endmodule

// File: tb/tb_multiply_accumulate_unit.sv
// Directed self-checking bench for multiply_accumulate_unit (WIDTH=32, STAGES=3).
module tb_multiply_accumulate_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mac_if #(.WIDTH(32)) bus ();

  multiply_accumulate_unit #(.WIDTH(32), .STAGES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one op with out_ready=1 and wait (bounded) for its result.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d, output int lat);
    bus.in_valid   = 1'b1;
    bus.in_opcode  = op;
    bus.in_a       = a;
    bus.in_b       = b;
    bus.in_c       = c;
    bus.in_d       = d;
    bus.in_dest_lo = 4'h3;
    bus.in_dest_hi = 4'hA;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, c, d;
    logic [63:0] res;
    logic        lng;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat;
    int idx;
    int oidx;
    int extra;
    int seen;
    logic        prev_stalled;
    logic [63:0] snap_res;
    logic [3:0]  snap_lo;
    logic        snap_long;

    checks = 0;
    errors = 0;
    vecs[0] = '{4'b0000, 32'd2, 32'd3, 32'd0, 32'd0, 64'd6, 1'b0};
    vecs[1] = '{4'b0001, 32'd4, 32'd5, 32'd7, 32'd0, 64'd27, 1'b0};
    vecs[2] = '{4'b0100, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, 64'h0000_0001_0000_0000, 1'b1};
    vecs[3] = '{4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 64'd1, 1'b1};
    vecs[4] = '{4'b0111, 32'hFFFF_FFFE, 32'd3, 32'd10, 32'd0, 64'd4, 1'b1};
    vecs[5] = '{4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 64'd1, 1'b0};
    vecs[6] = '{4'b0101, 32'd2, 32'd3, 32'd4, 32'd5, 64'h0000_0005_0000_000A, 1'b1};
    vecs[7] = '{4'b0001, 32'h8000_0000, 32'd2, 32'd1, 32'd0, 64'd1, 1'b0};

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_opcode  = 4'd0;
    bus.in_a       = 32'd0;
    bus.in_b       = 32'd0;
    bus.in_c       = 32'd0;
    bus.in_d       = 32'd0;
    bus.in_dest_lo = 4'd0;
    bus.in_dest_hi = 4'd0;
    bus.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_out_valid",  64'(bus.out_valid),   64'd0);
    check("rst_out_result", bus.out_result,       64'd0);
    check("rst_out_long",   64'(bus.out_long),    64'd0);
    check("rst_dest_lo",    64'(bus.out_dest_lo), 64'd0);
    check("rst_dest_hi",    64'(bus.out_dest_hi), 64'd0);
    check("rst_illegal",    64'(bus.out_illegal), 64'd0);
    check("rst_flags",      64'(bus.out_flags),   64'd0);
    check("rst_in_ready",   64'(bus.in_ready),    64'd1);

    // mul 3*5, exact latency of 3
    run_op(4'b0000, 32'd3, 32'd5, 32'd0, 32'd0, lat);
    check("mul_latency", 64'(lat),             64'd3);
    check("mul_result",  bus.out_result,       64'd15);
    check("mul_long",    64'(bus.out_long),    64'd0);
    check("mul_dest_lo", 64'(bus.out_dest_lo), 64'h3);
    check("mul_dest_hi", 64'(bus.out_dest_hi), 64'hA);
    check("mul_illegal", 64'(bus.out_illegal), 64'd0);

    // smull -1 * 2
    run_op(4'b0110, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, lat);
    check("smull_latency", 64'(lat),          64'd3);
    check("smull_result",  bus.out_result,    64'hFFFF_FFFF_FFFF_FFFE);
    check("smull_long",    64'(bus.out_long), 64'd1);
`ifdef MAC_FLAGS_EN
    check("smull_flags",   64'(bus.out_flags), 64'b10);
`else
    check("smull_flags",   64'(bus.out_flags), 64'b00);
`endif

    // umlal max*max + 1
    run_op(4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, lat);
    check("umlal_latency", 64'(lat),          64'd3);
    check("umlal_result",  bus.out_result,    64'hFFFF_FFFE_0000_0002);
    check("umlal_long",    64'(bus.out_long), 64'd1);

    // umlal wrap to zero
    run_op(4'b0101, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("wrap_latency", 64'(lat),       64'd3);
    check("wrap_result",  bus.out_result, 64'd0);
`ifdef MAC_FLAGS_EN
    check("wrap_flags",   64'(bus.out_flags), 64'b01);
`else
    check("wrap_flags",   64'(bus.out_flags), 64'b00);
`endif

    // Illegal opcode
    run_op(4'b0010, 32'd3, 32'd5, 32'd0, 32'd0, lat);
    check("ill_latency", 64'(lat),             64'd3);
    check("ill_illegal", 64'(bus.out_illegal), 64'd1);
    check("ill_result",  bus.out_result,       64'd0);
    check("ill_long",    64'(bus.out_long),    64'd0);
    check("ill_flags",   64'(bus.out_flags),   64'd0);

    // drain
    repeat (4) @(posedge clk);
    #1;
    check("idle_out_valid", 64'(bus.out_valid), 64'd0);

    // Back-to-back stream with out_ready low for cycles 5..8
    idx = 0;
    oidx = 0;
    prev_stalled = 1'b0;
    snap_res = 64'd0;
    snap_lo = 4'd0;
    snap_long = 1'b0;
    for (int cyc = 0; cyc < 60 && oidx < 8; cyc++) begin
      bus.out_ready = (cyc >= 5 && cyc <= 8) ? 1'b0 : 1'b1;
      bus.in_valid  = (idx < 8) ? 1'b1 : 1'b0;
      if (idx < 8) begin
        bus.in_opcode  = vecs[idx].op;
        bus.in_a       = vecs[idx].a;
        bus.in_b       = vecs[idx].b;
        bus.in_c       = vecs[idx].c;
        bus.in_d       = vecs[idx].d;
        bus.in_dest_lo = 4'(idx);
        bus.in_dest_hi = 4'(idx + 8);
      end
      #1;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        if (prev_stalled) begin
          check("stall_hold_result", bus.out_result,       snap_res);
          check("stall_hold_dest",   64'(bus.out_dest_lo), 64'(snap_lo));
          check("stall_hold_long",   64'(bus.out_long),    64'(snap_long));
        end
        snap_res     = bus.out_result;
        snap_lo      = bus.out_dest_lo;
        snap_long    = bus.out_long;
        prev_stalled = 1'b1;
      end else begin
        prev_stalled = 1'b0;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        check("stream_result",  bus.out_result,       vecs[oidx].res);
        check("stream_long",    64'(bus.out_long),    64'(vecs[oidx].lng));
        check("stream_dest_lo", 64'(bus.out_dest_lo), 64'(oidx));
        check("stream_dest_hi", 64'(bus.out_dest_hi), 64'(oidx + 8));
        oidx++;
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        idx++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("stream_count", 64'(oidx), 64'd8);
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.out_valid === 1'b1) extra++;
      @(posedge clk); #1;
    end
    check("stream_no_dup", 64'(extra), 64'd0);

    // Reset with two ops in flight
    bus.in_valid  = 1'b1;
    bus.in_opcode = 4'b0000;
    bus.in_a      = 32'd7;
    bus.in_b      = 32'd9;
    @(posedge clk); #1;
    bus.in_a      = 32'd11;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid",  64'(bus.out_valid), 64'd0);
    check("midrst_out_result", bus.out_result,     64'd0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    check("midrst_discarded", 64'(seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
